// File: rtl/mux_2to1_rr_arbiter.sv
// Packet-level round-robin arbiter driving a shared 2:1 stream mux; the grant is held from the first beat through last.
// Define MUX_2TO1_RR_ARBITER_STATS_EN to add saturating per-port packet counters (pkt_cnt0/pkt_cnt1).
module mux_2to1_rr_arbiter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid0,
   input  logic [DATA_W-1:0] data0,
   input  logic              last0,
   output logic              ready0,
   input  logic              valid1,
   input  logic [DATA_W-1:0] data1,
   input  logic              last1,
   output logic              ready1,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy
`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
   ,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   last_grant;
   logic   done0, done1;

   // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      ready0    = 1'b0;
      ready1    = 1'b0;
      out_data  = sel ? data1 : data0;
      out_last  = sel ? last1 : last0;
      done0     = 1'b0;
      done1     = 1'b0;
      unique case (state)
         IDLE: begin
            // On a tie the port that did not win last time gets the grant.
            if (valid0 && valid1) state_nxt = last_grant ? GRANT0 : GRANT1;
            else if (valid0)      state_nxt = GRANT0;
            else if (valid1)      state_nxt = GRANT1;
         end
         GRANT0: begin
            out_valid = valid0;
            out_data  = data0;
            out_last  = last0;
            ready0    = out_ready;
            if (valid0 && out_ready && last0) begin
               state_nxt = IDLE;
               done0     = 1'b1;
            end
         end
         GRANT1: begin
            out_valid = valid1;
            out_data  = data1;
            out_last  = last1;
            ready1    = out_ready;
            if (valid1 && out_ready && last1) begin
               state_nxt = IDLE;
               done1     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         sel        <= 1'b0;
      end else begin
         state <= state_nxt;
         if (done0) last_grant <= 1'b0;
         if (done1) last_grant <= 1'b1;
         if (state == IDLE && state_nxt == GRANT0) sel <= 1'b0;
         if (state == IDLE && state_nxt == GRANT1) sel <= 1'b1;
      end
   end

   assign busy = (state != IDLE);

`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt0 <= '0;
         pkt_cnt1 <= '0;
      end else begin
         if (done0 && pkt_cnt0 != '1) pkt_cnt0 <= pkt_cnt0 + 1'b1;
         if (done1 && pkt_cnt1 != '1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mux_2to1_rr_arbiter.sv
// Self-checking bench for mux_2to1_rr_arbiter: directed scenarios plus randomized traffic against a packet-level model.
// Define MUX_2TO1_RR_ARBITER_STATS_EN to also exercise the packet counters (built with CNT_W=2).
module tb_mux_2to1_rr_arbiter;

   localparam int DATA_W = 8;
`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              valid0, last0, ready0;
   logic              valid1, last1, ready1;
   logic [DATA_W-1:0] data0, data1;
   logic              out_valid, out_last, out_ready;
   logic [DATA_W-1:0] out_data;
   logic              sel, busy;
`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
   logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
`endif

   always #5 clk = ~clk;

   mux_2to1_rr_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .valid0(valid0), .data0(data0), .last0(last0), .ready0(ready0),
      .valid1(valid1), .data1(data1), .last1(last1), .ready1(ready1),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .sel(sel), .busy(busy)
`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
      , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: who owns the sink (-1 = nobody), which port wins the next tie,
   // the select shown while idle, and completed-packet tallies.
   int   owner;
   int   prefer;
   logic sel_m;
   int   cnt_m [2];
   logic fire [2];

   task automatic model_reset();
      owner  = -1;
      prefer = 0;
      sel_m  = 1'b0;
      cnt_m[0] = 0;
      cnt_m[1] = 0;
   endtask

   // Check outputs for the current inputs, then advance one clock and update the model.
   task automatic step(input string tag);
      logic             e_valid, e_last, e_r0, e_r1;
      logic [DATA_W-1:0] e_data;
      logic v0, v1, l0, l1, r, o_rdy;
      #1;
      e_valid = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
      e_data  = sel_m ? data1 : data0;
      e_last  = sel_m ? last1 : last0;
      if (owner == 0) begin
         e_valid = valid0; e_data = data0; e_last = last0; e_r0 = out_ready;
      end else if (owner == 1) begin
         e_valid = valid1; e_data = data1; e_last = last1; e_r1 = out_ready;
      end
      check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
      check({tag, ".out_data"},  32'(out_data),  32'(e_data));
      check({tag, ".out_last"},  32'(out_last),  32'(e_last));
      check({tag, ".ready0"},    32'(ready0),    32'(e_r0));
      check({tag, ".ready1"},    32'(ready1),    32'(e_r1));
      check({tag, ".sel"},       32'(sel),       32'(sel_m));
      check({tag, ".busy"},      32'(busy),      32'(owner >= 0));
`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
      check({tag, ".pkt_cnt0"},  32'(pkt_cnt0),  32'(cnt_m[0]));
      check({tag, ".pkt_cnt1"},  32'(pkt_cnt1),  32'(cnt_m[1]));
`endif
      v0 = valid0; v1 = valid1; l0 = last0; l1 = last1; r = rst; o_rdy = out_ready;
      fire[0] = (owner == 0) && v0 && o_rdy && !r;
      fire[1] = (owner == 1) && v1 && o_rdy && !r;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (owner < 0) begin
         if (v0 && v1) owner = prefer;
         else if (v0)  owner = 0;
         else if (v1)  owner = 1;
         if (owner >= 0) sel_m = owner[0];
      end else if (fire[owner] && (owner == 0 ? l0 : l1)) begin
         if (cnt_m[owner] < (1 << CNT_W) - 1) cnt_m[owner]++;
         prefer = 1 - owner;
         owner  = -1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      valid0 = 1'b0; last0 = 1'b0; data0 = '0;
      valid1 = 1'b0; last1 = 1'b0; data1 = '0;
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) step("reset");
      rst = 1'b0;
   endtask

   // Random source state per port.
   int               src_len [2];
   int               src_idx [2];
   logic             src_pres [2];
   logic [DATA_W-1:0] src_data [2];

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;

      // 1: reset values
      do_reset(2);
      check("t1.out_valid", 32'(out_valid), 32'd0);
      check("t1.busy", 32'(busy), 32'd0);
      check("t1.sel", 32'(sel), 32'd0);

      // 2: single 3-beat packet on port 0
      out_ready = 1'b1;
      valid0 = 1'b1; data0 = 8'h11; last0 = 1'b0;
      step("t2.req");
      step("t2.b1");
      data0 = 8'h22;
      #1 check("t2.data2", 32'(out_data), 32'h22);
      step("t2.b2");
      data0 = 8'h33; last0 = 1'b1;
      #1 check("t2.data3", 32'(out_data), 32'h33);
      check("t2.last3", 32'(out_last), 32'd1);
      step("t2.b3");
      idle_inputs();
      #1 check("t2.busy_after", 32'(busy), 32'd0);
      step("t2.idle");

      // 3: both requesting 1-beat packets continuously, grants alternate from port 0
      do_reset(2);
      valid0 = 1'b1; data0 = 8'hA0; last0 = 1'b1;
      valid1 = 1'b1; data1 = 8'hB1; last1 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step("t3.idle");
         #1 check("t3.grant", 32'(sel), 32'(k % 2));
         check("t3.busy", 32'(busy), 32'd1);
         step("t3.beat");
      end
      idle_inputs();
      step("t3.drain");

      // 4: sink stall mid-packet on port 1 while port 0 waits
      valid1 = 1'b1; data1 = 8'hC1; last1 = 1'b0;
      step("t4.req");
      step("t4.b1");
      data1 = 8'hC2; last1 = 1'b1; valid0 = 1'b1; data0 = 8'h5A; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 check("t4.ready0", 32'(ready0), 32'd0);
         check("t4.ready1", 32'(ready1), 32'd0);
         check("t4.sel", 32'(sel), 32'd1);
         check("t4.held", 32'(out_data), 32'hC2);
         step("t4.stall");
      end
      out_ready = 1'b1;
      step("t4.b2");
      valid1 = 1'b0; last1 = 1'b0;
      step("t4.idle");
      #1 check("t4.next_grant", 32'(sel), 32'd0);
      last0 = 1'b1;
      step("t4.p0");
      idle_inputs();
      step("t4.drain");

      // 5: reset during beat 2 of a port-0 packet; port 0 must win the next tie
      valid0 = 1'b1; data0 = 8'h01; last0 = 1'b0;
      step("t5.req");
      step("t5.b1");
      data0 = 8'h02; rst = 1'b1;
      step("t5.rst");
      rst = 1'b0;
      #1 check("t5.busy", 32'(busy), 32'd0);
      valid1 = 1'b1; data1 = 8'h77; last1 = 1'b1;
      step("t5.idle");
      #1 check("t5.grant", 32'(sel), 32'd0);
      last0 = 1'b1;
      step("t5.p0");
      idle_inputs();
      step("t5.drain");

`ifdef MUX_2TO1_RR_ARBITER_STATS_EN
      // 6: port-1 counter saturates at all-ones
      do_reset(1);
      valid1 = 1'b1; data1 = 8'h99; last1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step("t6.idle");
         step("t6.beat");
         check("t6.cnt1", 32'(pkt_cnt1), 32'((k + 1 > 3) ? 3 : k + 1));
         check("t6.cnt0", 32'(pkt_cnt0), 32'd0);
      end
      idle_inputs();
      step("t6.drain");
`endif

      // Randomized traffic with gaps, stalls and occasional resets.
      for (int p = 0; p < 2; p++) begin
         src_len[p]  = $urandom_range(1, 4);
         src_idx[p]  = 0;
         src_pres[p] = 1'b0;
         src_data[p] = '0;
      end
      fire[0] = 1'b0;
      fire[1] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (fire[p]) begin
               src_pres[p] = 1'b0;
               src_idx[p]++;
               if (src_idx[p] == src_len[p]) begin
                  src_idx[p] = 0;
                  src_len[p] = $urandom_range(1, 4);
               end
            end
            if (!src_pres[p]) begin
               src_data[p] = DATA_W'($urandom);
               src_pres[p] = ($urandom_range(0, 3) != 0);
            end
         end
         valid0 = src_pres[0]; data0 = src_data[0]; last0 = (src_idx[0] == src_len[0] - 1);
         valid1 = src_pres[1]; data1 = src_data[1]; last1 = (src_idx[1] == src_len[1] - 1);
         out_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 299) == 0);
         step("rand");
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
